// File: rtl/mips_cache_wbuf_coalesce.sv
// mips_cache_wbuf_coalesce: coalescing store write buffer between the D-cache and an Avalon-MM write master
// Ports: clk/rst (async active-high); store side addr/write_en/writedata/byteenable -> accept;
// bus side waitrequest -> write_addr/write_data/write_byteenable/write_writeenable (head entry);
// forwarding lookup_addr -> lookup_data/lookup_byteenable/lookup_hit; status count/full/empty.
module mips_cache_wbuf_coalesce #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    write_en,
  input  logic [DATA_W-1:0]       writedata,
  input  logic [DATA_W/8-1:0]     byteenable,
  output logic                    accept,
  input  logic                    waitrequest,
  output logic [ADDR_W-1:0]       write_addr,
  output logic [DATA_W-1:0]       write_data,
  output logic [DATA_W/8-1:0]     write_byteenable,
  output logic                    write_writeenable,
  input  logic [ADDR_W-1:0]       lookup_addr,
  output logic [DATA_W-1:0]       lookup_data,
  output logic [DATA_W/8-1:0]     lookup_byteenable,
  output logic                    lookup_hit,
  output logic [DEPTH_BITS:0]     count,
  output logic                    full,
  output logic                    empty
);
  localparam int BE_W = DATA_W / 8;
  localparam int OFF = $clog2(BE_W);
  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam int WA_W = ADDR_W - OFF;
  logic [WA_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [BE_W-1:0] be_q [DEPTH];
  logic [DEPTH_BITS-1:0] head_q, head_d, tail_q, tail_d, newest, idx;
  logic [DEPTH_BITS:0] count_q, count_d;
  logic merge, push, pop;
  logic [DATA_W-1:0] merged;
  logic unused_lo;
  assign unused_lo = ^{addr[OFF-1:0], lookup_addr[OFF-1:0]};
  assign newest = tail_q - DEPTH_BITS'(1);
  assign count = count_q;
  assign full = count_q == (DEPTH_BITS+1)'(DEPTH);
  assign empty = count_q == '0;
  // count>=2 guarantees the newest entry is never the head being issued
  assign merge = write_en && count_q >= (DEPTH_BITS+1)'(2) && addr[ADDR_W-1:OFF] == addr_q[newest];
  // full uses the pre-edge count, so a same-cycle pop does not open a slot
  assign push = write_en && !merge && !full;
  assign pop = !empty && !waitrequest;
  assign accept = merge || push;
  assign head_d = head_q + DEPTH_BITS'(pop);
  assign tail_d = tail_q + DEPTH_BITS'(push);
  assign count_d = count_q + (DEPTH_BITS+1)'(push) - (DEPTH_BITS+1)'(pop);
  assign write_writeenable = !empty;
  assign write_addr = empty ? '0 : {addr_q[head_q], {OFF{1'b0}}};
  assign write_data = empty ? '0 : data_q[head_q];
  assign write_byteenable = empty ? '0 : be_q[head_q];
  assign lookup_hit = |lookup_byteenable;
  always_comb begin
    merged = data_q[newest];
    for (int b = 0; b < BE_W; b++)
      if (byteenable[b]) merged[b*8 +: 8] = writedata[b*8 +: 8];
  end
  // walk oldest to newest so the newest matching entry wins each lane
  always_comb begin
    lookup_data = '0;
    lookup_byteenable = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + DEPTH_BITS'(i);
      if (i < int'(count_q) && addr_q[idx] == lookup_addr[ADDR_W-1:OFF])
        for (int b = 0; b < BE_W; b++)
          if (be_q[idx][b]) begin
            lookup_data[b*8 +: 8] = data_q[idx][b*8 +: 8];
            lookup_byteenable[b] = 1'b1;
          end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q] <= addr[ADDR_W-1:OFF];
        data_q[tail_q] <= writedata;
        be_q[tail_q] <= byteenable;
      end
      if (merge) begin
        data_q[newest] <= merged;
        be_q[newest] <= be_q[newest] | byteenable;
      end
    end
  end
endmodule

// File: tb/tb_mips_cache_wbuf_coalesce.sv
// tb_mips_cache_wbuf_coalesce: directed self-checking bench for the coalescing write buffer
module tb_mips_cache_wbuf_coalesce;
  logic clk = 0, rst = 1;
  logic [31:0] addr = 0, writedata = 0, write_addr, write_data, lookup_addr = 0, lookup_data;
  logic [3:0] byteenable = 0, write_byteenable, lookup_byteenable;
  logic write_en = 0, accept, waitrequest = 1, write_writeenable, lookup_hit, full, empty;
  logic [3:0] count;
  int passed = 0, failed = 0, total = 0;
  mips_cache_wbuf_coalesce dut (
    .clk(clk), .rst(rst), .addr(addr), .write_en(write_en), .writedata(writedata),
    .byteenable(byteenable), .accept(accept), .waitrequest(waitrequest),
    .write_addr(write_addr), .write_data(write_data), .write_byteenable(write_byteenable),
    .write_writeenable(write_writeenable), .lookup_addr(lookup_addr), .lookup_data(lookup_data),
    .lookup_byteenable(lookup_byteenable), .lookup_hit(lookup_hit), .count(count),
    .full(full), .empty(empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic exp_acc);
    addr = a;
    writedata = d;
    byteenable = be;
    write_en = 1;
    #1 chk("accept", accept, exp_acc);
    tick();
    write_en = 0;
  endtask
  task automatic look(input logic [31:0] a, input logic [31:0] exp_d, input logic [3:0] exp_be);
    lookup_addr = a;
    #1;
    chk("lookup_data", lookup_data, exp_d);
    chk("lookup_be", lookup_byteenable, exp_be);
    chk("lookup_hit", lookup_hit, exp_be != 0);
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wwe", write_writeenable, 0);
    chk("rst_waddr", write_addr, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_wbe", write_byteenable, 0);
    look(32'h0, 32'h0, 4'h0);
    store(32'h100, 32'hAAAA0001, 4'hF, 1);
    store(32'h104, 32'hBBBB0002, 4'hF, 1);
    store(32'h108, 32'hCCCC0003, 4'hF, 1);
    chk("t1_count", count, 3);
    chk("t1_waddr", write_addr, 32'h100);
    tick();
    chk("t1_hold_waddr", write_addr, 32'h100);
    chk("t1_hold_wdata", write_data, 32'hAAAA0001);
    chk("t1_wwe", write_writeenable, 1);
    waitrequest = 0;
    tick();
    chk("t1_w2_addr", write_addr, 32'h104);
    chk("t1_w2_data", write_data, 32'hBBBB0002);
    tick();
    chk("t1_w3_addr", write_addr, 32'h108);
    chk("t1_w3_count", count, 1);
    tick();
    chk("t1_empty", empty, 1);
    chk("t1_wwe_off", write_writeenable, 0);
    waitrequest = 1;
    store(32'h200, 32'h0, 4'hF, 1);
    store(32'h300, 32'h11, 4'h1, 1);
    store(32'h301, 32'h2200, 4'h2, 1);
    chk("t2_merge_count", count, 2);
    look(32'h300, 32'h00002211, 4'h3);
    store(32'h200, 32'h33, 4'h1, 1);
    chk("t2_nomerge_count", count, 3);
    look(32'h200, 32'h00000033, 4'hF);
    waitrequest = 0;
    tick();
    chk("t2_e1_addr", write_addr, 32'h300);
    chk("t2_e1_data", write_data, 32'h2211);
    chk("t2_e1_be", write_byteenable, 4'h3);
    tick();
    chk("t2_e2_data", write_data, 32'h33);
    chk("t2_e2_be", write_byteenable, 4'h1);
    tick();
    chk("t2_empty", empty, 1);
    waitrequest = 1;
    for (int i = 0; i < 8; i++) store(32'h1000 + 32'(4 * i), 32'(i + 1), 4'hF, 1);
    chk("t3_full", full, 1);
    chk("t3_count", count, 8);
    store(32'h2000, 32'h99, 4'hF, 0);
    chk("t3_rej_count", count, 8);
    addr = 32'h2000;
    writedata = 32'h99;
    write_en = 1;
    waitrequest = 0;
    #1 chk("t3_full_pop_accept", accept, 0);
    tick();
    chk("t3_after_pop_count", count, 7);
    waitrequest = 1;
    #1 chk("t3_reaccept", accept, 1);
    tick();
    write_en = 0;
    chk("t3_wrap_count", count, 8);
    chk("t3_wrap_full", full, 1);
    chk("t3_head", write_addr, 32'h1004);
    look(32'h2000, 32'h99, 4'hF);
    waitrequest = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("t3_drained", empty, 1);
    waitrequest = 1;
    store(32'h3F0, 32'h0, 4'hF, 1);
    store(32'h400, 32'h44332211, 4'hF, 1);
    store(32'h400, 32'h00FF0000, 4'h4, 1);
    chk("t4_count", count, 2);
    look(32'h400, 32'h44FF2211, 4'hF);
    look(32'h402, 32'h44FF2211, 4'hF);
    look(32'h500, 32'h0, 4'h0);
    waitrequest = 0;
    store(32'h403, 32'h55000000, 4'h8, 1);
    chk("t4_mp_count", count, 1);
    chk("t4_mp_addr", write_addr, 32'h400);
    chk("t4_mp_data", write_data, 32'h55FF2211);
    tick();
    chk("t4_empty", empty, 1);
    waitrequest = 1;
    store(32'h600, 32'h66, 4'hF, 1);
    waitrequest = 0;
    store(32'h700, 32'h77, 4'hF, 1);
    waitrequest = 1;
    chk("t5_count", count, 1);
    chk("t5_head_addr", write_addr, 32'h700);
    chk("t5_head_data", write_data, 32'h77);
    for (int i = 0; i < 4; i++) store(32'h800 + 32'(4 * i), 32'(i), 4'hF, 1);
    chk("t6_count", count, 5);
    #2 rst = 1;
    #1;
    chk("t6_wwe", write_writeenable, 0);
    chk("t6_count0", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_waddr", write_addr, 0);
    tick();
    rst = 0;
    look(32'h700, 32'h0, 4'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
